// File: rtl/weight_load_seq.sv
// Weight load sequencer. For each filter of a job it clears the weight FIFO
// and store, streams ceil(R*S/4) words from the source into the FIFO, asks
// the weight store to load, and holds the store valid until compute is done.
module weight_load_seq #(
  parameter int unsigned INPUT_WIDTH  = 32,
  parameter int unsigned NF_WIDTH     = 16,
  parameter int unsigned LOAD_TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   START,
  input  logic [NF_WIDTH-1:0]    NUM_FILTERS,
  input  logic [3:0]             PARAM_R,
  input  logic [3:0]             PARAM_S,
  input  logic                   S_VALID,
  input  logic [INPUT_WIDTH-1:0] S_DATA,
  output logic                   S_READY,
  output logic                   FIFO_WR_CMD,
  output logic [INPUT_WIDTH-1:0] FIFO_WR_DATA,
  input  logic                   FIFO_FULL,
  output logic                   CLEAR_FIFO,
  output logic                   LOAD_WS,
  input  logic                   LOADING_WS,
  input  logic                   WS_FULL,
  output logic                   WS_RESETN,
  output logic                   WS_VALID,
  input  logic                   COMPUTE_DONE,
  output logic [NF_WIDTH-1:0]    FILTER_IDX,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERROR
);

  localparam int unsigned WORD_W = 3;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned TMO_W  = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FILL   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_HOLD   = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                clr_second_q, clr_second_d;
  logic [WORD_W-1:0]   words_q, words_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [NF_WIDTH-1:0] num_filt_q, num_filt_d;
  logic [NF_WIDTH-1:0] idx_q, idx_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                clear_fifo_q, clear_fifo_d;
  logic                ws_resetn_q, ws_resetn_d;
  logic                load_ws_q, load_ws_d;
  logic                ws_valid_q, ws_valid_d;
  logic                done_q, done_d;

  logic [PROD_W-1:0]   rs_prod;
  logic [WORD_W-1:0]   words_calc;
  logic                start_legal;
  logic                in_fill;
  logic                push;

  // Job geometry: number of 4-weight words per filter and START legality
  assign rs_prod     = PROD_W'(PARAM_R) * PROD_W'(PARAM_S);
  assign words_calc  = WORD_W'((rs_prod + PROD_W'(3)) >> 2);
  assign start_legal = (PARAM_R != 4'd0) && (PARAM_R <= 4'd5) &&
                       (PARAM_S != 4'd0) && (PARAM_S <= 4'd5) &&
                       (NUM_FILTERS != '0);

  // Source-to-FIFO handshake is combinational so a word moves every cycle
  assign in_fill      = (state_q == ST_FILL);
  assign S_READY      = in_fill && (word_cnt_q != '0) && !FIFO_FULL;
  assign push         = S_VALID && S_READY;
  assign FIFO_WR_CMD  = push;
  assign FIFO_WR_DATA = in_fill ? S_DATA : '0;

  assign CLEAR_FIFO = clear_fifo_q;
  assign LOAD_WS    = load_ws_q;
  assign WS_RESETN  = ws_resetn_q;
  assign WS_VALID   = ws_valid_q;
  assign FILTER_IDX = idx_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERROR      = error_q;

  // State register, counters and registered outputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= ST_IDLE;
      clr_second_q <= 1'b0;
      words_q      <= '0;
      word_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      num_filt_q   <= '0;
      idx_q        <= '0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      clear_fifo_q <= 1'b0;
      ws_resetn_q  <= 1'b1;
      load_ws_q    <= 1'b0;
      ws_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_second_q <= clr_second_d;
      words_q      <= words_d;
      word_cnt_q   <= word_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      num_filt_q   <= num_filt_d;
      idx_q        <= idx_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      clear_fifo_q <= clear_fifo_d;
      ws_resetn_q  <= ws_resetn_d;
      load_ws_q    <= load_ws_d;
      ws_valid_q   <= ws_valid_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they
  // register in step with the state they belong to
  always_comb begin
    state_d      = state_q;
    clr_second_d = clr_second_q;
    words_d      = words_q;
    word_cnt_d   = word_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    num_filt_d   = num_filt_q;
    idx_d        = idx_q;
    error_d      = error_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (start_legal) begin
            num_filt_d   = NUM_FILTERS;
            words_d      = words_calc;
            idx_d        = '0;
            error_d      = 1'b0;
            clr_second_d = 1'b0;
            state_d      = ST_CLEAR;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (!clr_second_q) begin
          clr_second_d = 1'b1;
        end else begin
          word_cnt_d = words_q;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (word_cnt_q == '0) begin
          tmo_cnt_d = '0;
          state_d   = ST_LOAD;
        end else if (push) begin
          word_cnt_d = word_cnt_q - WORD_W'(1);
        end
      end
      ST_LOAD: begin
        if (WS_FULL && !LOADING_WS) begin
          state_d = ST_HOLD;
        end else if (tmo_cnt_q == TMO_W'(LOAD_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_HOLD: begin
        if (COMPUTE_DONE) begin
          if (idx_q == num_filt_q - NF_WIDTH'(1)) begin
            state_d = ST_FINISH;
          end else begin
            idx_d        = idx_q + NF_WIDTH'(1);
            clr_second_d = 1'b0;
            state_d      = ST_CLEAR;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d       = (state_d != ST_IDLE);
    clear_fifo_d = (state_d == ST_CLEAR);
    ws_resetn_d  = !((state_d == ST_CLEAR) && !clr_second_d);
    load_ws_d    = (state_d == ST_LOAD);
    ws_valid_d   = (state_d == ST_HOLD);
    done_d       = (state_d == ST_FINISH);
  end

endmodule

// File: doc/weight_load_seq.md
WEIGHT_LOAD_SEQ -- requirements
Module: weight_load_seq

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 32, the weight word width (four 8-bit weights per word).
REQ-002 SHALL have parameter NF_WIDTH, default 16, the filter-count width.
REQ-003 SHALL have parameter LOAD_TIMEOUT, default 64, the maximum number of cycles spent in LOAD.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have these ports:
- CLK  in  1  clock.
- RESETN  in  1  asynchronous active-low reset.
- START  in  1  single-cycle request to begin a job.
- NUM_FILTERS  in  NF_WIDTH  number of filters in the job.
- PARAM_R  in  4  filter height, legal range 1..5.
- PARAM_S  in  4  filter width, legal range 1..5.
- S_VALID  in  1  weight source word valid.
- S_DATA  in  INPUT_WIDTH  weight source word.
- S_READY  out  1  weight source word accepted.
- FIFO_WR_CMD  out  1  weight FIFO push.
- FIFO_WR_DATA  out  INPUT_WIDTH  weight FIFO push data.
- FIFO_FULL  in  1  weight FIFO full.
- CLEAR_FIFO  out  1  weight FIFO clear, level signal.
- LOAD_WS  out  1  weight store load request, level signal.
- LOADING_WS  in  1  weight store load in progress.
- WS_FULL  in  1  weight store full.
- WS_RESETN  out  1  active-low weight store clear.
- WS_VALID  out  1  weight store holds the current filter.
- COMPUTE_DONE  in  1  compute engine has finished with the current filter.
- FILTER_IDX  out  NF_WIDTH  index of the current filter.
- BUSY  out  1  job in progress.
- DONE  out  1  single-cycle job-complete pulse.
- ERROR  out  1  sticky error flag.

Function
REQ-006 SHALL implement the FSM states IDLE, CLEAR, FILL, LOAD, HOLD and FINISH.
REQ-007 In IDLE, START with legal parameters SHALL latch NUM_FILTERS, PARAM_R and PARAM_S, and SHALL set WORDS = ceil(R*S/4), a 3-bit value in the range 1..7.
REQ-008 In the same cycle as REQ-007, FILTER_IDX SHALL be set to 0, ERROR SHALL be cleared and the FSM SHALL move to CLEAR.
REQ-009 START is illegal if R is 0 or greater than 5, if S is 0 or greater than 5, or if NUM_FILTERS is 0; an illegal START SHALL set ERROR and leave the FSM in IDLE.
REQ-010 START outside IDLE SHALL be ignored.
REQ-011 CLEAR SHALL last exactly 2 cycles, with CLEAR_FIFO=1 in both cycles and WS_RESETN=0 in the first cycle only, then move to FILL with the word counter loaded with WORDS.
REQ-012 In FILL, S_READY SHALL equal (word counter not 0) AND NOT FIFO_FULL, computed combinationally.
REQ-013 In FILL, FIFO_WR_CMD SHALL equal S_VALID AND S_READY, FIFO_WR_DATA SHALL equal S_DATA, and each push SHALL decrement the word counter.
REQ-014 In FILL, when the word counter reaches 0 (registered), the FSM SHALL move to LOAD and the timeout counter SHALL be cleared.
REQ-015 In every state other than FILL, S_READY and FIFO_WR_CMD SHALL be 0.
REQ-016 In LOAD, LOAD_WS SHALL be 1; in every other state LOAD_WS SHALL be 0, so that each filter presents a fresh rising edge.
REQ-017 LOAD SHALL move to HOLD when WS_FULL=1 and LOADING_WS=0 in the same cycle.
REQ-018 If LOAD lasts LOAD_TIMEOUT cycles without the REQ-017 exit condition, the FSM SHALL set ERROR and return to IDLE without pulsing DONE.
REQ-019 In HOLD, WS_VALID SHALL be 1; outside HOLD, WS_VALID SHALL be 0.
REQ-020 In HOLD, on COMPUTE_DONE: if FILTER_IDX equals NUM_FILTERS-1 the FSM SHALL move to FINISH; otherwise FILTER_IDX SHALL be incremented and the FSM SHALL move to CLEAR.
REQ-021 COMPUTE_DONE outside HOLD SHALL be ignored.
REQ-022 FINISH SHALL drive DONE=1 for exactly 1 cycle and then move to IDLE.
REQ-023 BUSY SHALL be 1 in every state except IDLE.
REQ-024 If COMPUTE_DONE and WS_FULL arrive in the same cycle, only the input relevant to the current state SHALL take effect.
REQ-025 FILTER_IDX SHALL hold its last value in IDLE until the next legal START.

Reset
REQ-026 RESETN=0 SHALL immediately force the FSM to IDLE, all counters to 0 and FILTER_IDX to 0, including when asserted mid-job.
REQ-027 During reset, every output SHALL be 0 except WS_RESETN, which SHALL be 1.
REQ-028 After RESETN is released, no output SHALL change until a legal START is received.

Verification
REQ-029 The bench SHALL cover: START with R=3, S=3, NUM_FILTERS=2, source always valid -> CLEAR_FIFO high for 2 cycles, 3 pushes, LOAD_WS high until WS_FULL, WS_VALID, FILTER_IDX 0 then 1, one DONE pulse.
REQ-030 The bench SHALL cover: R=5, S=5 with FIFO_FULL held for 4 cycles mid-FILL -> S_READY=0 during the stall, exactly 7 pushes in total, no push while FIFO_FULL=1.
REQ-031 The bench SHALL cover: START with R=0, or with NUM_FILTERS=0 -> ERROR=1, BUSY stays 0, and the next legal START clears ERROR.
REQ-032 The bench SHALL cover: WS_FULL never asserted in LOAD -> after 64 cycles ERROR=1, state IDLE, no DONE pulse.
REQ-033 The bench SHALL cover: RESETN pulsed low during HOLD of filter 1 -> all outputs at reset values immediately, and the next START restarts at FILTER_IDX=0.
REQ-034 The bench SHALL cover: START and COMPUTE_DONE pulsed during FILL -> both ignored, and word count and FILTER_IDX unchanged.
